// File: rtl/surfboard_mm_seq.sv
// surfboard_mm_seq: sequential N x N integer matrix multiplier, C = A * B.
// Operands are taken over a valid/ready handshake. One k-slice is accumulated
// per cycle across N*N parallel MAC lanes. The result is returned over a
// valid/ready handshake.
// Optional build macro SURFBOARD_MM_SAT_EN: saturating narrowing plus the
// sat_flag output port. When the macro is undefined, narrowing wraps.
module surfboard_mm_seq #(
   parameter int N      = 2,
   parameter int W      = 8,
   parameter bit SIGNED = 1'b1,
   parameter int ACC_W  = 2*W + $clog2(N) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [0:N*N-1][W-1:0]    A,
   input  logic [0:N*N-1][W-1:0]    B,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [0:N*N-1][W-1:0]    C
`ifdef SURFBOARD_MM_SAT_EN
   ,
   output logic                     sat_flag
`endif
);

   localparam int L  = N * N;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam int IW = (L > 1) ? $clog2(L) : 1;

`ifdef SURFBOARD_MM_SAT_EN
   localparam logic [ACC_W-1:0] SMAX = (ACC_W'(1) << (W-1)) - ACC_W'(1);
   localparam logic [ACC_W-1:0] SMIN = ~SMAX;
   localparam logic [ACC_W-1:0] UMAX = (ACC_W'(1) << W) - ACC_W'(1);
`endif

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    state, state_next;
   logic [KW-1:0]             k;
   logic                      last;
   logic [0:L-1][W-1:0]       a_reg, b_reg;
   logic [0:L-1][ACC_W-1:0]   acc, acc_next;
   logic [0:L-1][W-1:0]       c_next;
`ifdef SURFBOARD_MM_SAT_EN
   logic                      sat_next;
`endif

   assign last      = (k == KW'(N-1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Full-precision product at 2W bits, extended to the accumulator width.
   function automatic logic [ACC_W-1:0] mac_term(input logic [W-1:0] x,
                                                  input logic [W-1:0] y);
      logic [2*W-1:0] xe, ye, p;
      if (SIGNED) begin
         xe = (2*W)'($signed(x));
         ye = (2*W)'($signed(y));
      end else begin
         xe = (2*W)'(x);
         ye = (2*W)'(y);
      end
      p = xe * ye;
      if (SIGNED) return ACC_W'($signed(p));
      else        return ACC_W'(p);
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic for the accept / accumulate / hold sequence.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = RUN;
         RUN:     if (last)      state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Lane arithmetic: next accumulator values and the narrowed result.
   always_comb begin
      int unsigned row, col;
      logic [IW-1:0] ia, ib;
      acc_next = acc;
      c_next   = '0;
`ifdef SURFBOARD_MM_SAT_EN
      sat_next = 1'b0;
`endif
      for (int unsigned l = 0; l < L; l++) begin
         row = l / N;
         col = l % N;
         ia  = IW'(row * N + int'(k));
         ib  = IW'(int'(k) * N + col);
         acc_next[l] = acc[l] + mac_term(a_reg[ia], b_reg[ib]);
`ifdef SURFBOARD_MM_SAT_EN
         if (SIGNED) begin
            if ($signed(acc_next[l]) > $signed(SMAX)) begin
               c_next[l] = SMAX[W-1:0];
               sat_next  = 1'b1;
            end else if ($signed(acc_next[l]) < $signed(SMIN)) begin
               c_next[l] = SMIN[W-1:0];
               sat_next  = 1'b1;
            end else begin
               c_next[l] = acc_next[l][W-1:0];
            end
         end else begin
            if (acc_next[l] > UMAX) begin
               c_next[l] = UMAX[W-1:0];
               sat_next  = 1'b1;
            end else begin
               c_next[l] = acc_next[l][W-1:0];
            end
         end
`else
         c_next[l] = acc_next[l][W-1:0];
`endif
      end
   end

   // Operand capture, accumulation, k counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         k        <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         acc      <= '0;
         C        <= '0;
`ifdef SURFBOARD_MM_SAT_EN
         sat_flag <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= A;
                  b_reg <= B;
                  acc   <= '0;
                  k     <= '0;
               end
            end
            RUN: begin
               acc <= acc_next;
               if (last) begin
                  k        <= '0;
                  C        <= c_next;
`ifdef SURFBOARD_MM_SAT_EN
                  sat_flag <= sat_next;
`endif
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_surfboard_mm_seq.sv
// Testbench for surfboard_mm_seq: four configurations, table vectors,
// hand-written multi-cycle sequences and randomized checks against a
// plain-arithmetic matrix product model.
module tb_surfboard_mm_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam int PN[4] = '{2, 2, 3, 4};
   localparam int PW[4] = '{8, 4, 16, 8};
   localparam int PS[4] = '{1, 0, 1, 0};
`ifdef SURFBOARD_MM_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   int   checks = 0;
   int   errors = 0;
   int   sa[16], sb[16];
   logic rst[4], iv[4], ordy[4], ir[4], ov[4];
   logic sf[4];

   logic [0:3][7:0]   a0, b0, c0;
   logic [0:3][3:0]   a1, b1, c1;
   logic [0:8][15:0]  a2, b2, c2;
   logic [0:15][7:0]  a3, b3, c3;

   // Operand buses of every instance follow the shared stimulus arrays.
   always_comb begin
      for (int e = 0; e < 4; e++) begin
         a0[e] = sa[e][7:0];  b0[e] = sb[e][7:0];
         a1[e] = sa[e][3:0];  b1[e] = sb[e][3:0];
      end
      for (int e = 0; e < 9; e++) begin
         a2[e] = sa[e][15:0]; b2[e] = sb[e][15:0];
      end
      for (int e = 0; e < 16; e++) begin
         a3[e] = sa[e][7:0];  b3[e] = sb[e][7:0];
      end
   end

`ifndef SURFBOARD_MM_SAT_EN
   always_comb for (int e = 0; e < 4; e++) sf[e] = 1'b0;
`endif

   surfboard_mm_seq #(.N(2), .W(8), .SIGNED(1'b1)) u0 (
      .clk(clk), .rst(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]), .A(a0), .B(b0),
      .out_valid(ov[0]), .out_ready(ordy[0]), .C(c0)
`ifdef SURFBOARD_MM_SAT_EN
      , .sat_flag(sf[0])
`endif
   );
   surfboard_mm_seq #(.N(2), .W(4), .SIGNED(1'b0)) u1 (
      .clk(clk), .rst(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]), .A(a1), .B(b1),
      .out_valid(ov[1]), .out_ready(ordy[1]), .C(c1)
`ifdef SURFBOARD_MM_SAT_EN
      , .sat_flag(sf[1])
`endif
   );
   surfboard_mm_seq #(.N(3), .W(16), .SIGNED(1'b1)) u2 (
      .clk(clk), .rst(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]), .A(a2), .B(b2),
      .out_valid(ov[2]), .out_ready(ordy[2]), .C(c2)
`ifdef SURFBOARD_MM_SAT_EN
      , .sat_flag(sf[2])
`endif
   );
   surfboard_mm_seq #(.N(4), .W(8), .SIGNED(1'b0)) u3 (
      .clk(clk), .rst(rst[3]), .in_valid(iv[3]), .in_ready(ir[3]), .A(a3), .B(b3),
      .out_valid(ov[3]), .out_ready(ordy[3]), .C(c3)
`ifdef SURFBOARD_MM_SAT_EN
      , .sat_flag(sf[3])
`endif
   );

   typedef struct {
      int a[4];
      int b[4];
      int cw[4];
      int cs[4];
      bit sat;
   } vec_t;

   function automatic longint get_c(input int sel, input int e);
      case (sel)
         0:       return longint'(c0[2'(e)]);
         1:       return longint'(c1[2'(e)]);
         2:       return longint'(c2[4'(e)]);
         default: return longint'(c3[4'(e)]);
      endcase
   endfunction

   function automatic longint ext(input int x, input int w, input bit s);
      longint mask = (longint'(1) << w) - 1;
      longint v = longint'(x) & mask;
      if (s && v[w-1]) v = v - (longint'(1) << w);
      return v;
   endfunction

   // Reference: textbook triple loop on integers, then the narrowing rule.
   function automatic void model(input int sel, output longint ex[16], output bit es);
      int n = PN[sel];
      int w = PW[sel];
      bit s = PS[sel][0];
      longint mask = (longint'(1) << w) - 1;
      longint hi = s ? (longint'(1) << (w-1)) - 1 : mask;
      longint lo = s ? -(longint'(1) << (w-1)) : 0;
      es = 1'b0;
      for (int e = 0; e < 16; e++) ex[e] = 0;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++) begin
            longint sum = 0;
            for (int kk = 0; kk < n; kk++)
               sum += ext(sa[i*n+kk], w, s) * ext(sb[kk*n+j], w, s);
            if (SAT && sum > hi) begin sum = hi; es = 1'b1; end
            else if (SAT && sum < lo) begin sum = lo; es = 1'b1; end
            ex[i*n+j] = sum & mask;
         end
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_c(input int sel, input string nm, input longint ex[16], input bit es);
      for (int e = 0; e < PN[sel]*PN[sel]; e++)
         chk($sformatf("%s C[%0d]", nm, e), get_c(sel, e), ex[e]);
      chk({nm, " sat_flag"}, longint'(sf[sel]), longint'(es));
   endtask

   task automatic randomize_ops(input int sel);
      for (int e = 0; e < PN[sel]*PN[sel]; e++) begin
         sa[e] = int'($urandom);
         sb[e] = int'($urandom);
      end
   endtask

   // One accepted transaction with out_ready held high: checks latency,
   // the result, the one-cycle out_valid pulse and the return to IDLE.
   task automatic run_one(input int sel, input string nm, input longint ex[16], input bit es);
      int cnt;
      @(negedge clk);
      chk({nm, " in_ready before"}, longint'(ir[sel]), 1);
      iv[sel] = 1'b1;
      ordy[sel] = 1'b1;
      @(posedge clk); #1;
      iv[sel] = 1'b0;
      cnt = 0;
      while (ov[sel] !== 1'b1 && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({nm, " latency"}, cnt, PN[sel]);
      check_c(sel, nm, ex, es);
      @(posedge clk); #1;
      chk({nm, " out_valid drop"}, longint'(ov[sel]), 0);
      chk({nm, " in_ready back"}, longint'(ir[sel]), 1);
   endtask

   vec_t   tbl[5];
   longint ex[16];
   bit     es;

   initial begin
      tbl[0] = '{a:'{1, 2, 3, 4},         b:'{5, 6, 7, 8},
                 cw:'{19, 22, 43, 50},    cs:'{19, 22, 43, 50},     sat:1'b0};
      tbl[1] = '{a:'{-1, 0, 0, -1},       b:'{3, 4, 5, 6},
                 cw:'{'hFD, 'hFC, 'hFB, 'hFA}, cs:'{'hFD, 'hFC, 'hFB, 'hFA}, sat:1'b0};
      tbl[2] = '{a:'{-128, -128, -128, -128}, b:'{-128, -128, -128, -128},
                 cw:'{0, 0, 0, 0},        cs:'{'h7F, 'h7F, 'h7F, 'h7F}, sat:1'b1};
      tbl[3] = '{a:'{127, 127, 0, 0},     b:'{127, 0, 127, 0},
                 cw:'{2, 0, 0, 0},        cs:'{'h7F, 0, 0, 0},      sat:1'b1};
      tbl[4] = '{a:'{-128, 0, 0, 1},      b:'{1, 0, 0, -128},
                 cw:'{'h80, 0, 0, 'h80},  cs:'{'h80, 0, 0, 'h80},   sat:1'b0};

      for (int s = 0; s < 4; s++) begin
         rst[s] = 1'b1; iv[s] = 1'b0; ordy[s] = 1'b0;
      end
      for (int e = 0; e < 16; e++) begin sa[e] = 0; sb[e] = 0; end

      // Reset state of every instance.
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) begin
         chk($sformatf("reset%0d in_ready", s), longint'(ir[s]), 1);
         chk($sformatf("reset%0d out_valid", s), longint'(ov[s]), 0);
         for (int e = 0; e < PN[s]*PN[s]; e++)
            chk($sformatf("reset%0d C[%0d]", s, e), get_c(s, e), 0);
         chk($sformatf("reset%0d sat_flag", s), longint'(sf[s]), 0);
      end
      @(negedge clk);
      for (int s = 0; s < 4; s++) rst[s] = 1'b0;

      // Table vectors on the N=2, W=8 signed instance.
      for (int v = 0; v < 5; v++) begin
         for (int e = 0; e < 16; e++) ex[e] = 0;
         for (int e = 0; e < 4; e++) begin
            sa[e] = tbl[v].a[e];
            sb[e] = tbl[v].b[e];
            ex[e] = SAT ? tbl[v].cs[e] : tbl[v].cw[e];
         end
         run_one(0, $sformatf("vec%0d", v), ex, SAT ? tbl[v].sat : 1'b0);
      end

      // Unsigned W=4, all elements 15.
      for (int e = 0; e < 16; e++) ex[e] = 0;
      for (int e = 0; e < 4; e++) begin
         sa[e] = 15; sb[e] = 15;
         ex[e] = SAT ? 15 : 2;
      end
      run_one(1, "all15", ex, SAT);

      // Backpressure: result held while out_ready is low, new input ignored.
      for (int e = 0; e < 4; e++) begin
         sa[e] = e + 1; sb[e] = e + 5;
      end
      model(0, ex, es);
      @(negedge clk);
      iv[0] = 1'b1; ordy[0] = 1'b0;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      begin
         int cnt = 0;
         while (ov[0] !== 1'b1 && cnt < 40) begin @(posedge clk); #1; cnt++; end
         chk("bp latency", cnt, 2);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         iv[0] = 1'b1;
         randomize_ops(0);
         chk($sformatf("bp%0d out_valid", c), longint'(ov[0]), 1);
         chk($sformatf("bp%0d in_ready", c), longint'(ir[0]), 0);
         check_c(0, $sformatf("bp%0d", c), ex, es);
      end
      @(negedge clk);
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp retire out_valid", longint'(ov[0]), 0);
      chk("bp retire in_ready", longint'(ir[0]), 1);
      iv[0] = 1'b0;
      @(posedge clk); #1;
      chk("bp idle in_ready", longint'(ir[0]), 1);

      // Reset mid-RUN on N=4 after a completed result left C nonzero.
      for (int e = 0; e < 16; e++) begin sa[e] = e + 1; sb[e] = 16 - e; end
      model(3, ex, es);
      run_one(3, "n4 first", ex, es);
      randomize_ops(3);
      @(negedge clk);
      iv[3] = 1'b1;
      @(posedge clk); #1;
      iv[3] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      rst[3] = 1'b1;
      @(posedge clk); #1;
      chk("midrst in_ready", longint'(ir[3]), 1);
      chk("midrst out_valid", longint'(ov[3]), 0);
      for (int e = 0; e < 16; e++)
         chk($sformatf("midrst C[%0d]", e), get_c(3, e), 0);
      chk("midrst sat_flag", longint'(sf[3]), 0);
      @(negedge clk);
      rst[3] = 1'b0;
      randomize_ops(3);
      model(3, ex, es);
      run_one(3, "n4 after rst", ex, es);

      // Randomized single transactions.
      for (int r = 0; r < 9; r++) begin
         int sel = (r % 3 == 0) ? 0 : (r % 3 == 1) ? 1 : 3;
         randomize_ops(sel);
         model(sel, ex, es);
         run_one(sel, $sformatf("rand%0d", r), ex, es);
      end

      // Back-to-back stream on N=3, W=16 with in_valid and out_ready high.
      begin
         longint q[$];
         bit     qs[$];
         int     sent = 0, got = 0, cyc = 0;
         int     acc_cyc[4], out_cyc[4];
         ordy[2] = 1'b1;
         while (got < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ov[2] === 1'b1) begin
               for (int e = 0; e < 9; e++)
                  chk($sformatf("b2b%0d C[%0d]", got, e), get_c(2, e), q.pop_front());
               chk($sformatf("b2b%0d sat_flag", got), longint'(sf[2]), longint'(qs.pop_front()));
               out_cyc[got] = cyc;
               got++;
            end
            if (sent < 4) randomize_ops(2);
            if (ir[2] === 1'b1 && sent < 4) begin
               model(2, ex, es);
               for (int e = 0; e < 9; e++) q.push_back(ex[e]);
               qs.push_back(es);
               acc_cyc[sent] = cyc;
               sent++;
               iv[2] = 1'b1;
            end else begin
               iv[2] = (sent < 4);
            end
         end
         iv[2] = 1'b0;
         chk("b2b results", got, 4);
         if (got == 4) begin
            for (int i = 1; i < 4; i++)
               chk($sformatf("b2b interval%0d", i), acc_cyc[i] - acc_cyc[i-1], 5);
            for (int i = 0; i < 4; i++)
               chk($sformatf("b2b latency%0d", i), out_cyc[i] - acc_cyc[i], 4);
         end
      end

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/surfboard_mm_seq.md
Name: surfboard_mm_seq

Overview:
Sequential, parametrised N×N integer matrix multiplier computing C = A·B. It is the multi-cycle successor to the combinational 2×2 surfboard product. It accepts whole operand matrices over a valid/ready input handshake and accumulates one k-slice per cycle across N² parallel MAC lanes. It returns the W-bit result matrix over a valid/ready output handshake, sitting between the operand staging buffers and the result writeback path.

Parameters:
N, 2, matrix dimension (N≥1); matrices are N×N.
W, 8, element width in bits for A, B and C.
SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned.
ACC_W, 2*W+$clog2(N)+1, internal accumulator width; must be ≥ 2*W+$clog2(N) so accumulation never overflows.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operand matrices A, B valid.
in_ready  output  1  block can accept operands.
A  input  [0:N*N-1][W-1:0]  matrix A, row-major; element (i,k) at index i*N+k.
B  input  [0:N*N-1][W-1:0]  matrix B, row-major; element (k,j) at index k*N+j.
out_valid  output  1  C holds a completed result.
out_ready  input  1  downstream accepts C.
C  output  [0:N*N-1][W-1:0]  result matrix, row-major; element (i,j) at index i*N+j.

Behaviour:
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- Reset (rst high at an edge): state→IDLE, k counter→0, all accumulators→0, C→0, out_valid=0, in_ready=1 in the following cycle. Reset takes effect from any state, including mid-RUN or DONE with results pending; the in-flight result is discarded.
- IDLE: on in_valid&&in_ready at an edge, register A and B internally, clear all accumulators, set k=0, go to RUN. A and B may change freely after acceptance.
- RUN: each cycle, every lane (i,j) does acc[i][j] += A[i][k]*B[k][j]. Products are formed at 2W bits and sign- or zero-extended to ACC_W according to SIGNED. k increments each cycle. At the edge where k==N-1, go to DONE and load C from the final accumulators.
- Timing: out_valid rises exactly N cycles after the accepting edge.
- Narrowing, default: C[i*N+j] = low W bits of acc[i][j] (modular wrap).
- DONE: C and out_valid are held stable until out_valid&&out_ready at an edge, then go to IDLE. in_ready is 0 throughout RUN and DONE. Input is never accepted in the same cycle as output retires.
- Throughput: with out_ready=1 and in_valid=1 continuously, one result every N+2 cycles.
- in_valid while in_ready=0 is ignored; no queueing.
- N=1: RUN lasts one cycle, producing C = A·B with the same narrowing rules.

Optional Feature:
SURFBOARD_MM_SAT_EN
- Defined: narrowing saturates instead of wrapping.
  - SIGNED=1: clamp to [-2^(W-1), 2^(W-1)-1].
  - SIGNED=0: clamp to [0, 2^W-1].
  - Adds output port sat_flag (1 bit), registered with C. It is 1 if any element clamped in that result, and reset to 0.
- Undefined: modular wrap as in Behaviour; sat_flag port does not exist.

Test Plan:
1. N=2, W=8, SIGNED=1, A=[1,2,3,4], B=[5,6,7,8], out_ready=1 -> C=[19,22,43,50]; out_valid rises 2 cycles after accept and is high for 1 cycle.
2. N=2, W=8, SIGNED=1, A=[-1,0,0,-1], B=[3,4,5,6] -> C=[-3,-4,-5,-6] (0xFD,0xFC,0xFB,0xFA).
3. N=2, W=4, SIGNED=0, all A and B elements = 15 -> C elements = 2 (450 mod 16); with SURFBOARD_MM_SAT_EN -> C elements = 15 and sat_flag=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> C stable, out_valid=1, in_ready=0, and a new in_valid is not accepted. Raise out_ready -> IDLE next cycle with in_ready=1.
5. Reset mid-RUN (N=4, rst asserted at k=2) -> next cycle state IDLE, in_ready=1, out_valid=0, C=0. A fresh operand pair then yields the correct product with no residue.
6. N=3, W=16, SIGNED=1, back-to-back: 4 random operand pairs with in_valid and out_ready held 1 -> results match the reference model in order, one every 5 cycles.
